// File: rtl/sram_pkg.sv
// Shared types and elaboration-time helpers for the request/response SRAM model.
package sram_pkg;

    typedef enum logic [1:0] {
        ST_INIT = 2'd0,
        ST_IDLE = 2'd1,
        ST_BUSY = 2'd2,
        ST_RESP = 2'd3
    } sram_state_e;

    function automatic int be_width(input int data_width);
        return data_width / 8;
    endfunction

    // Index width for the storage array; a one-word array still needs a 1-bit index.
    function automatic int idx_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    function automatic bit params_ok(input int data_width, input int addr_width,
                                     input int depth, input int latency);
        return (data_width > 0) && (data_width % 8 == 0) && (latency >= 1) &&
               (depth >= 1) && (depth <= (1 << addr_width));
    endfunction

endpackage

// File: rtl/sram_byte_array.sv
// DEPTH x DATA_WIDTH storage with a byte-masked synchronous write and a synchronous read.
module sram_byte_array
    import sram_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 16,
    parameter int IDX_WIDTH  = 4
) (
    input  logic                        clk,
    input  logic                        we,
    input  logic                        re,
    input  logic [IDX_WIDTH-1:0]        addr,
    input  logic [DATA_WIDTH-1:0]       wdata,
    input  logic [be_width(DATA_WIDTH)-1:0] be,
    output logic [DATA_WIDTH-1:0]       rdata
);

    localparam int BE_W = be_width(DATA_WIDTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        for (int b = 0; b < BE_W; b++) begin
            if (we && be[b]) begin
                mem[addr][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
        if (re) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/sram_req_resp.sv
// Single-port SRAM with valid/ready requests, fixed-latency registered responses and a clear sweep.
module sram_req_resp
    import sram_pkg::*;
#(
    parameter int DATA_WIDTH     = 16,
    parameter int ADDR_WIDTH     = 14,
    parameter int DEPTH          = 2**ADDR_WIDTH,
    parameter int LATENCY        = 1,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic                            req_valid,
    output logic                            req_ready,
    input  logic                            req_we,
    input  logic [ADDR_WIDTH-1:0]           req_addr,
    input  logic [DATA_WIDTH-1:0]           req_wdata,
    input  logic [be_width(DATA_WIDTH)-1:0] req_be,
    output logic                            resp_valid,
    output logic [DATA_WIDTH-1:0]           resp_rdata,
    output logic                            resp_err,
    output logic                            init_done,
    output logic [1:0]                      dbg_state
);

    localparam int BE_W     = be_width(DATA_WIDTH);
    localparam int IW       = idx_width(DEPTH);
    localparam int CNT_W    = $clog2(LATENCY) + 1;
    localparam int PTR_W    = $clog2(DEPTH) + 1;
    localparam int LAT_LAST = (LATENCY >= 2) ? LATENCY - 2 : 0;

    if (!params_ok(DATA_WIDTH, ADDR_WIDTH, DEPTH, LATENCY)) begin : g_param_err
        $error("sram_req_resp: illegal DATA_WIDTH/ADDR_WIDTH/DEPTH/LATENCY");
    end

    sram_state_e       state, next_state;
    logic [CNT_W-1:0]  lat_cnt;
    logic [PTR_W-1:0]  init_ptr;
    logic              pend_we, pend_err, init_done_q;
    logic              accept, in_range, last_ptr;
    logic              arr_we, arr_re;
    logic [IW-1:0]     arr_addr;
    logic [DATA_WIDTH-1:0] arr_wdata, arr_rdata;
    logic [BE_W-1:0]   arr_be;

    assign accept   = req_valid && (state == ST_IDLE);
    assign in_range = ({1'b0, req_addr} < (ADDR_WIDTH+1)'(DEPTH));
    assign last_ptr = (init_ptr == PTR_W'(DEPTH - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= CLEAR_ON_RESET ? ST_INIT : ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_INIT: if (last_ptr) next_state = ST_IDLE;
            ST_IDLE: if (accept) next_state = (LATENCY == 1) ? ST_RESP : ST_BUSY;
            ST_BUSY: if (lat_cnt == CNT_W'(LAT_LAST)) next_state = ST_RESP;
            ST_RESP: next_state = ST_IDLE;
            default: next_state = ST_IDLE;
        endcase
    end

    // Response attributes are captured at acceptance; read data lives in the array's read register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lat_cnt     <= '0;
            init_ptr    <= '0;
            pend_we     <= 1'b0;
            pend_err    <= 1'b0;
            init_done_q <= 1'b0;
        end else begin
            if (state == ST_INIT) init_ptr <= init_ptr + PTR_W'(1);
            if (accept) begin
                lat_cnt  <= '0;
                pend_we  <= req_we;
                pend_err <= !in_range;
            end else if (state == ST_BUSY) begin
                lat_cnt <= lat_cnt + CNT_W'(1);
            end
            if (next_state != ST_INIT) init_done_q <= 1'b1;
        end
    end

    always_comb begin
        req_ready  = (state == ST_IDLE);
        resp_valid = (state == ST_RESP);
        resp_err   = resp_valid && pend_err;
        resp_rdata = (resp_valid && !pend_we && !pend_err) ? arr_rdata : '0;
        init_done  = init_done_q;
        dbg_state  = state;
        arr_we     = (state == ST_INIT) || (accept && req_we && in_range);
        arr_re     = accept && !req_we && in_range;
        arr_addr   = (state == ST_INIT) ? IW'(init_ptr) : IW'(req_addr);
        arr_wdata  = (state == ST_INIT) ? '0 : req_wdata;
        arr_be     = (state == ST_INIT) ? '1 : req_be;
    end

    sram_byte_array #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .IDX_WIDTH  (IW)
    ) u_array (
        .clk   (clk),
        .we    (arr_we),
        .re    (arr_re),
        .addr  (arr_addr),
        .wdata (arr_wdata),
        .be    (arr_be),
        .rdata (arr_rdata)
    );

endmodule

// File: tb/tb_sram_req_resp.sv
// Bench for sram_req_resp: two configurations checked every cycle against a transaction-level model.
module tb_sram_req_resp;
  import sram_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n    [2];
  logic        req_valid  [2];
  logic        req_we     [2];
  logic [3:0]  req_addr   [2];
  logic [15:0] req_wdata  [2];
  logic [1:0]  req_be     [2];
  logic        req_ready  [2];
  logic        resp_valid [2];
  logic [15:0] resp_rdata [2];
  logic        resp_err   [2];
  logic        init_done  [2];
  logic [1:0]  dbg_state  [2];

  int total = 0;
  int bad   = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  sram_req_resp #(.DATA_WIDTH(16), .ADDR_WIDTH(4), .DEPTH(16), .LATENCY(1), .CLEAR_ON_RESET(1'b1)) dut0 (
    .clk(clk), .reset_n(reset_n[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_we(req_we[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .req_be(req_be[0]),
    .resp_valid(resp_valid[0]), .resp_rdata(resp_rdata[0]), .resp_err(resp_err[0]),
    .init_done(init_done[0]), .dbg_state(dbg_state[0]));

  sram_req_resp #(.DATA_WIDTH(16), .ADDR_WIDTH(4), .DEPTH(12), .LATENCY(3), .CLEAR_ON_RESET(1'b1)) dut1 (
    .clk(clk), .reset_n(reset_n[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_we(req_we[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .req_be(req_be[1]),
    .resp_valid(resp_valid[1]), .resp_rdata(resp_rdata[1]), .resp_err(resp_err[1]),
    .init_done(init_done[1]), .dbg_state(dbg_state[1]));

  function automatic int dep(input int i);
    return (i == 0) ? 16 : 12;
  endfunction

  function automatic int lat(input int i);
    return (i == 0) ? 1 : 3;
  endfunction

  task automatic chk(input string nm, input int i, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s inst%0d: got %0h expected %0h at %0t", nm, i, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model + scoreboard ----------------
  // Handshake rule: a request is taken in a cycle where req_valid and req_ready are both high.
  // Model view: cycle t after reset release is ready iff t >= DEPTH (sweep done) and t >= the
  // first free cycle after the previous response; a request taken in t responds in t+LATENCY.
  typedef struct packed {
    logic        inst;
    int          due;
    logic        err;
    logic [15:0] data;
  } exp_t;

  exp_t        exp_q [$];
  int          cyc   [2];
  int          free  [2];
  logic [15:0] mem_m [2][16];

  initial begin
    forever begin
      @(posedge clk);
      for (int i = 0; i < 2; i++) begin
        if (!reset_n[i]) begin
          cyc[i]  = 0;
          free[i] = 0;
          for (int k = exp_q.size() - 1; k >= 0; k--) if (exp_q[k].inst == 1'(i)) exp_q.delete(k);
          for (int a = 0; a < 16; a++) mem_m[i][a] = 16'h0;
        end else begin
          if (req_valid[i] && cyc[i] >= dep(i) && cyc[i] >= free[i]) begin
            exp_t e;
            int   a;
            bit   inr;
            a      = int'(req_addr[i]);
            inr    = (a < dep(i));
            e.inst = 1'(i);
            e.due  = cyc[i] + lat(i);
            e.err  = !inr;
            e.data = 16'h0;
            if (req_we[i]) begin
              if (inr) begin
                for (int b = 0; b < 2; b++)
                  if (req_be[i][b]) mem_m[i][a][8*b +: 8] = req_wdata[i][8*b +: 8];
              end
            end else if (inr) begin
              e.data = mem_m[i][a];
            end
            exp_q.push_back(e);
            free[i] = cyc[i] + lat(i) + 1;
          end
          cyc[i]++;
        end
      end
    end
  end

  // One compare process: every cycle, every output of both instances.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      for (int i = 0; i < 2; i++) begin
        int   idx;
        logic ev;
        logic ee;
        logic [15:0] ed;
        idx = -1;
        for (int k = exp_q.size() - 1; k >= 0; k--) begin
          if (exp_q[k].inst == 1'(i) && exp_q[k].due < cyc[i]) begin
            chk("resp_missing", i, 32'(exp_q[k].due), 32'(cyc[i]));
            exp_q.delete(k);
          end
        end
        foreach (exp_q[k]) if (exp_q[k].inst == 1'(i) && exp_q[k].due == cyc[i]) idx = k;
        ev = (idx >= 0);
        ee = ev ? exp_q[idx].err : 1'b0;
        ed = ev ? exp_q[idx].data : 16'h0;
        if (ev) exp_q.delete(idx);
        chk("req_ready",  i, 32'(req_ready[i]),  32'(cyc[i] >= dep(i) && cyc[i] >= free[i]));
        chk("init_done",  i, 32'(init_done[i]),  32'(cyc[i] >= dep(i)));
        chk("resp_valid", i, 32'(resp_valid[i]), 32'(ev));
        chk("resp_err",   i, 32'(resp_err[i]),   32'(ee));
        chk("resp_rdata", i, 32'(resp_rdata[i]), 32'(ed));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_req(input int i, input logic we, input logic [3:0] a, input logic [15:0] wd,
                        input logic [1:0] be, output logic [15:0] rd, output logic er,
                        output int acc_c, output int rsp_c);
    int n;
    rd = 16'h0; er = 1'b0; acc_c = 0; rsp_c = 0;
    @(negedge clk);
    req_valid[i] = 1'b1; req_we[i] = we; req_addr[i] = a; req_wdata[i] = wd; req_be[i] = be;
    n = 0;
    while (!req_ready[i] && n < 200) begin @(negedge clk); n++; end
    if (n >= 200) begin
      total++; bad++;
      $display("FAIL accept_timeout inst%0d: no req_ready within 200 cycles", i);
      req_valid[i] = 1'b0;
      return;
    end
    acc_c = cyc[i];
    @(negedge clk);
    req_valid[i] = 1'b0;
    n = 0;
    while (!resp_valid[i] && n < 20) begin @(negedge clk); n++; end
    if (n >= 20) begin
      total++; bad++;
      $display("FAIL resp_timeout inst%0d: no resp_valid within 20 cycles", i);
      return;
    end
    rd = resp_rdata[i]; er = resp_err[i]; rsp_c = cyc[i];
  endtask

  task automatic count_init(input int i, input int exp_cycles);
    int k;
    k = 0;
    do begin
      @(posedge clk); #1; k++;
    end while (!init_done[i] && k < 100);
    chk("init_cycles", i, 32'(k), 32'(exp_cycles));
  endtask

  task automatic rand_run(input int i, input int n);
    logic [15:0] rd;
    logic        er;
    int          ac, rc;
    for (int t = 0; t < n; t++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      do_req(i, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 16'($urandom),
             2'($urandom_range(0, 3)), rd, er, ac, rc);
    end
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    logic [15:0] rd;
    logic        er;
    int          ac, rc, ca, cb, lowcnt;
    for (int i = 0; i < 2; i++) begin
      reset_n[i] = 1'b1; req_valid[i] = 1'b0; req_we[i] = 1'b0;
      req_addr[i] = '0; req_wdata[i] = '0; req_be[i] = '0;
    end
    #1;
    reset_n[0] = 1'b0; reset_n[1] = 1'b0;
    #1;
    chk("rst_ready", 0, 32'(req_ready[0]), 0);
    chk("rst_resp_valid", 0, 32'(resp_valid[0]), 0);
    chk("rst_init_done", 1, 32'(init_done[1]), 0);
    repeat (3) @(negedge clk);
    reset_n[0] = 1'b1; reset_n[1] = 1'b1;
    fork
      count_init(0, 16);
      count_init(1, 12);
    join

    // sweep leaves every word zero
    for (int a = 0; a < 16; a++) begin
      do_req(0, 1'b0, 4'(a), 16'h0, 2'b00, rd, er, ac, rc);
      chk("clear_rdata", 0, 32'(rd), 0);
      chk("clear_err", 0, 32'(er), 0);
    end

    // LATENCY=1 full write, then partial write over it
    do_req(0, 1'b1, 4'd3, 16'hA5C3, 2'b11, rd, er, ac, rc);
    chk("wr_resp_rdata", 0, 32'(rd), 0);
    do_req(0, 1'b0, 4'd3, 16'h0, 2'b00, rd, er, ac, rc);
    chk("rd_a5c3", 0, 32'(rd), 32'hA5C3);
    chk("lat1", 0, 32'(rc - ac), 1);
    do_req(0, 1'b1, 4'd3, 16'h00FF, 2'b01, rd, er, ac, rc);
    do_req(0, 1'b0, 4'd3, 16'h0, 2'b10, rd, er, ac, rc);
    chk("rd_a5ff", 0, 32'(rd), 32'hA5FF);

    // LATENCY=3 back-to-back with req_valid held
    @(negedge clk);
    req_valid[1] = 1'b1; req_we[1] = 1'b1; req_addr[1] = 4'd5; req_wdata[1] = 16'hBEEF; req_be[1] = 2'b11;
    lowcnt = 0;
    while (!req_ready[1] && lowcnt < 50) begin @(negedge clk); lowcnt++; end
    ca = cyc[1];
    @(negedge clk);
    req_we[1] = 1'b0;
    lowcnt = 0;
    while (!req_ready[1] && lowcnt < 20) begin lowcnt++; @(negedge clk); end
    chk("busy_ready_low", 1, 32'(lowcnt), 3);
    cb = cyc[1];
    chk("b2b_gap", 1, 32'(cb - ca), 4);
    @(negedge clk);
    req_valid[1] = 1'b0;
    lowcnt = 0;
    while (!resp_valid[1] && lowcnt < 20) begin @(negedge clk); lowcnt++; end
    chk("b2b_rdata", 1, 32'(resp_rdata[1]), 32'hBEEF);

    // out-of-range on DEPTH=12
    do_req(1, 1'b1, 4'd11, 16'h5A5A, 2'b11, rd, er, ac, rc);
    chk("lat3", 1, 32'(rc - ac), 3);
    do_req(1, 1'b1, 4'd13, 16'h1234, 2'b11, rd, er, ac, rc);
    chk("oor_wr_err", 1, 32'(er), 1);
    chk("oor_wr_rdata", 1, 32'(rd), 0);
    do_req(1, 1'b0, 4'd13, 16'h0, 2'b00, rd, er, ac, rc);
    chk("oor_rd_err", 1, 32'(er), 1);
    chk("oor_rd_rdata", 1, 32'(rd), 0);
    do_req(1, 1'b0, 4'd11, 16'h0, 2'b00, rd, er, ac, rc);
    chk("rd11_err", 1, 32'(er), 0);
    chk("rd11_rdata", 1, 32'(rd), 32'h5A5A);

    // reset while BUSY
    @(negedge clk);
    req_valid[1] = 1'b1; req_we[1] = 1'b0; req_addr[1] = 4'd11;
    lowcnt = 0;
    while (!req_ready[1] && lowcnt < 50) begin @(negedge clk); lowcnt++; end
    @(negedge clk);
    req_valid[1] = 1'b0;
    reset_n[1] = 1'b0;
    #1;
    chk("midrst_resp_valid", 1, 32'(resp_valid[1]), 0);
    chk("midrst_ready", 1, 32'(req_ready[1]), 0);
    chk("midrst_init_done", 1, 32'(init_done[1]), 0);
    chk("midrst_rdata", 1, 32'(resp_rdata[1]), 0);
    chk("midrst_err", 1, 32'(resp_err[1]), 0);
    repeat (3) @(negedge clk);
    reset_n[1] = 1'b1;
    count_init(1, 12);

    fork
      rand_run(0, 80);
      rand_run(1, 60);
    join
    repeat (6) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
